async_fifo_rd_ctrl: RTL and testbench
=====================================

// Module: async_fifo_rd_ctrl
// PURPOSE
//  Read-side pointer/flag controller of an async FIFO, in the read clock domain.
//  - Synchronises the write-domain Gray pointer through a flop chain.
//  - Converts the synchronised pointer to binary with the team's Gray-to-binary rule.
//  - Owns the read pointer; produces the RAM read address, empty/almost_empty and occupancy.
//  - Returns the Gray read pointer to the write domain.
// PARAMETERS
//  ADDR_WIDTH   8   RAM address width; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
//  SYNC_STAGES  2   flops in the wr_ptr_gray synchroniser chain (>=2)
//  AE_THRESH    2   almost_empty asserted while rd_level <= AE_THRESH
// PORTS
//  sys_clk      in   1             read-domain clock, all logic on rising edge
//  sys_rst      in   1             synchronous reset, active-high
//  wr_ptr_gray  in   ADDR_WIDTH+1  write pointer, Gray coded, registered in write domain
//  rd_req       in   1             pop request
//  rd_ack       out  1             pop accepted this cycle (combinational: rd_req & ~empty)
//  rd_addr      out  ADDR_WIDTH    RAM read address = rd_ptr_bin[ADDR_WIDTH-1:0]
//  rd_ptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer to write domain
//  empty        out  1             registered, FIFO empty as seen by read side
//  almost_empty out  1             registered, rd_level <= AE_THRESH
//  rd_level     out  ADDR_WIDTH+1  registered occupancy, 0..2**ADDR_WIDTH
// BEHAVIOUR
//  Reset (sys_rst=1 at an edge):
//   - Sync chain, rd_ptr_bin, rd_ptr_gray, rd_addr and rd_level clear to 0.
//   - empty=1, almost_empty=1.
//   - rd_req is ignored and rd_ack=0 while sys_rst=1.
//  Reset mid-operation gives the same result. The write side is reset in the same window.
//  Synchroniser: sync[0] <= wr_ptr_gray; sync[k] <= sync[k-1]. wsync = sync[SYNC_STAGES-1].
//  Conversion: wbin[i] = ^(wsync >> i), combinational, full ADDR_WIDTH+1 bits.
//  Pop:
//   - rd_ack=1 -> rd_ptr_bin_nxt = rd_ptr_bin+1, modulo 2**(ADDR_WIDTH+1). Otherwise rd_ptr_bin_nxt = rd_ptr_bin.
//   - Each edge: rd_ptr_bin <= rd_ptr_bin_nxt; rd_ptr_gray <= nxt ^ (nxt>>1).
//   - rd_addr therefore advances on the edge that consumes rd_ack.
//  Flags:
//   - rd_level <= (wbin - rd_ptr_bin_nxt) mod 2**(ADDR_WIDTH+1).
//   - empty <= (rd_level_nxt == 0); almost_empty <= (rd_level_nxt <= AE_THRESH).
//   - Invariant: empty == (rd_level == 0) on every cycle.
//  Latency: a wr_ptr_gray change is visible in empty/rd_level on the (SYNC_STAGES+1)th
//   rising edge after it. A pop is reflected in rd_addr/rd_ptr_gray/empty/rd_level on the next edge.
//  Boundaries:
//   - rd_req while empty: rd_ack=0, no state change.
//   - Last entry popped: empty=1 next edge, unless a newer wsync arrives on that same edge.
//   - Simultaneous pop and wsync advance: level = wbin - (rd_ptr_bin+1).
//   - Full: rd_level = 2**ADDR_WIDTH, MSBs of pointers differ. This is legal, no saturation.
//   - Wrap: rd_ptr_bin all-ones -> 0; rd_ptr_gray 100..0 -> 000..0; rd_addr max -> 0.
//   - wr_ptr_gray must step by one Gray code per write clock. Other jumps are a write-side protocol violation; the block still computes level arithmetically.
// TESTING (ADDR_WIDTH=8, SYNC_STAGES=2, AE_THRESH=2)
//  1 Reset with wr_ptr_gray=0 -> empty=1, almost_empty=1, rd_addr=0, rd_ptr_gray=9'h000, rd_level=0.
//  2 Write and pop:
//    - wr_ptr_gray 0 -> 9'h001 -> empty falls and rd_level=1 on 3rd edge.
//    - Then rd_req for 1 cycle -> rd_ack=1, next edge: rd_addr=1, rd_ptr_gray=9'h001, empty=1.
//  3 Pop while empty: rd_req held 5 cycles with wr_ptr_gray=0 -> rd_ack=0 throughout, rd_addr=0, rd_ptr_gray unchanged.
//  4 Full: wr_ptr_gray=9'h180 (bin 256) from reset -> on 3rd edge rd_level=256, empty=0, almost_empty=0.
//  5 Wrap:
//    - Set rd_ptr_bin=511 (rd_ptr_gray=9'h100) with wbin=0 (one entry).
//    - Pop -> rd_ack=1, next edge rd_addr 255 -> 0, rd_ptr_gray=9'h000, empty=1.
//  6 Reset mid-op: rd_level=5, rd_addr=3, rd_req=1, sys_rst=1 for 1 cycle -> next edge all reset values, rd_ack=0 during reset.

Source files
------------

// File: rtl/async_fifo_rd_ctrl_if.sv
// Read-side port bundle of the async FIFO: write-domain pointer in, pop handshake,
// RAM address, flags and the Gray read pointer back out.
interface async_fifo_rd_ctrl_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH:0]   wr_ptr_gray;
    logic                  rd_req;
    logic                  rd_ack;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   rd_ptr_gray;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   rd_level;

    modport master (
        output wr_ptr_gray, rd_req,
        input  rd_ack, rd_addr, rd_ptr_gray, empty, almost_empty, rd_level
    );

    modport slave (
        input  wr_ptr_gray, rd_req,
        output rd_ack, rd_addr, rd_ptr_gray, empty, almost_empty, rd_level
    );
endinterface

// File: rtl/async_fifo_rd_ctrl.sv
// Read-domain pointer/flag controller of an async FIFO: synchronises the write
// Gray pointer, owns the read pointer and derives empty/almost_empty/occupancy.
module async_fifo_rd_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    async_fifo_rd_ctrl_if.slave   bus
);
    localparam int PW = ADDR_WIDTH + 1;

    logic [SYNC_STAGES-1:0][PW-1:0] sync;
    logic [PW-1:0] wsync;
    logic [PW-1:0] wbin;
    logic [PW-1:0] rd_ptr_bin;
    logic [PW-1:0] rd_ptr_bin_nxt;
    logic [PW-1:0] rd_ptr_gray;
    logic [PW-1:0] rd_level;
    logic [PW-1:0] rd_level_nxt;
    logic          empty;
    logic          almost_empty;
    logic          rd_ack;

    assign wsync = sync[SYNC_STAGES-1];

    always_comb begin
        wbin = '0;
        for (int i = 0; i < PW; i++)
            wbin[i] = ^(wsync >> i);
    end

    // Pops are refused during reset so the pointer cannot move in the reset cycle.
    assign rd_ack         = bus.rd_req & ~empty & ~sys_rst;
    assign rd_ptr_bin_nxt = rd_ptr_bin + PW'(rd_ack);
    // Modular difference: a full FIFO (MSBs differ) yields exactly 2**ADDR_WIDTH.
    assign rd_level_nxt   = wbin - rd_ptr_bin_nxt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync         <= '0;
            rd_ptr_bin   <= '0;
            rd_ptr_gray  <= '0;
            rd_level     <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
        end else begin
            sync[0] <= bus.wr_ptr_gray;
            for (int k = 1; k < SYNC_STAGES; k++)
                sync[k] <= sync[k-1];
            rd_ptr_bin   <= rd_ptr_bin_nxt;
            rd_ptr_gray  <= rd_ptr_bin_nxt ^ (rd_ptr_bin_nxt >> 1);
            rd_level     <= rd_level_nxt;
            empty        <= (rd_level_nxt == '0);
            almost_empty <= (rd_level_nxt <= PW'(AE_THRESH));
        end
    end

    assign bus.rd_ack       = rd_ack;
    assign bus.rd_addr      = rd_ptr_bin[ADDR_WIDTH-1:0];
    assign bus.rd_ptr_gray  = rd_ptr_gray;
    assign bus.empty        = empty;
    assign bus.almost_empty = almost_empty;
    assign bus.rd_level     = rd_level;
endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed bench for async_fifo_rd_ctrl (ADDR_WIDTH=8, SYNC_STAGES=2, AE_THRESH=2).
module tb_async_fifo_rd_ctrl;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    async_fifo_rd_ctrl_if #(.ADDR_WIDTH(8)) bus ();

    async_fifo_rd_ctrl #(.ADDR_WIDTH(8), .SYNC_STAGES(2), .AE_THRESH(2)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // {empty, almost_empty, rd_addr, rd_ptr_gray, rd_level}
    logic [27:0] st;
    assign st = {bus.empty, bus.almost_empty, bus.rd_addr, bus.rd_ptr_gray, bus.rd_level};

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        bus.wr_ptr_gray = 9'h000;
        bus.rd_req = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic pop_n(input int n);
        bus.rd_req = 1'b1;
        repeat (n) @(negedge sys_clk);
        bus.rd_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (st !== {1'b1, 1'b1, 8'd0, 9'h000, 9'd0}) begin
            miscompares++;
            $display("FAIL reset_state got %h want %h", st, {1'b1, 1'b1, 8'd0, 9'h000, 9'd0});
        end
    endtask

    task automatic test_write_pop();
        do_reset();
        bus.wr_ptr_gray = 9'h001;
        repeat (2) @(negedge sys_clk);
        vectors++;
        if (bus.empty !== 1'b1 || bus.rd_level !== 9'd0) begin
            miscompares++;
            $display("FAIL wp_latency_2edges got empty=%b level=%0d want 1/0", bus.empty, bus.rd_level);
        end
        @(negedge sys_clk);
        vectors++;
        if (st !== {1'b0, 1'b1, 8'd0, 9'h000, 9'd1}) begin
            miscompares++;
            $display("FAIL wp_visible_3rd got %h want %h", st, {1'b0, 1'b1, 8'd0, 9'h000, 9'd1});
        end
        bus.rd_req = 1'b1;
        #1;
        vectors++;
        if (bus.rd_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL wp_ack got %b want 1", bus.rd_ack);
        end
        @(negedge sys_clk);
        bus.rd_req = 1'b0;
        vectors++;
        if (st !== {1'b1, 1'b1, 8'd1, 9'h001, 9'd0}) begin
            miscompares++;
            $display("FAIL wp_after_pop got %h want %h", st, {1'b1, 1'b1, 8'd1, 9'h001, 9'd0});
        end
    endtask

    task automatic test_pop_empty();
        do_reset();
        bus.rd_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (bus.rd_ack !== 1'b0 || bus.rd_addr !== 8'd0 || bus.rd_ptr_gray !== 9'h000) begin
                miscompares++;
                $display("FAIL pop_empty[%0d] got ack=%b addr=%0d gray=%h want 0/0/000",
                         i, bus.rd_ack, bus.rd_addr, bus.rd_ptr_gray);
            end
            @(negedge sys_clk);
        end
        bus.rd_req = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        bus.wr_ptr_gray = 9'h180;
        repeat (2) @(negedge sys_clk);
        vectors++;
        if (bus.rd_level !== 9'd0) begin
            miscompares++;
            $display("FAIL full_latency got level=%0d want 0", bus.rd_level);
        end
        @(negedge sys_clk);
        vectors++;
        if (st !== {1'b0, 1'b0, 8'd0, 9'h000, 9'd256}) begin
            miscompares++;
            $display("FAIL full_level got %h want %h", st, {1'b0, 1'b0, 8'd0, 9'h000, 9'd256});
        end
    endtask

    task automatic test_almost_empty();
        do_reset();
        bus.wr_ptr_gray = 9'h002;             // bin 3
        repeat (3) @(negedge sys_clk);
        vectors++;
        if (st !== {1'b0, 1'b0, 8'd0, 9'h000, 9'd3}) begin
            miscompares++;
            $display("FAIL ae_level3 got %h want %h", st, {1'b0, 1'b0, 8'd0, 9'h000, 9'd3});
        end
        pop_n(1);
        vectors++;
        if (st !== {1'b0, 1'b1, 8'd1, 9'h001, 9'd2}) begin
            miscompares++;
            $display("FAIL ae_level2 got %h want %h", st, {1'b0, 1'b1, 8'd1, 9'h001, 9'd2});
        end
    endtask

    task automatic test_simul_pop_advance();
        do_reset();
        bus.wr_ptr_gray = 9'h001;             // bin 1
        repeat (3) @(negedge sys_clk);
        bus.wr_ptr_gray = 9'h003;             // bin 2
        repeat (2) @(negedge sys_clk);        // wsync now bin 2, level reg still 1
        pop_n(1);
        vectors++;
        if (st !== {1'b0, 1'b1, 8'd1, 9'h001, 9'd1}) begin
            miscompares++;
            $display("FAIL simul_pop got %h want %h", st, {1'b0, 1'b1, 8'd1, 9'h001, 9'd1});
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.wr_ptr_gray = 9'h180;             // bin 256
        repeat (3) @(negedge sys_clk);
        pop_n(256);
        bus.wr_ptr_gray = 9'h100;             // bin 511
        repeat (3) @(negedge sys_clk);
        pop_n(255);
        vectors++;
        if (st !== {1'b1, 1'b1, 8'd255, 9'h100, 9'd0}) begin
            miscompares++;
            $display("FAIL wrap_at_511 got %h want %h", st, {1'b1, 1'b1, 8'd255, 9'h100, 9'd0});
        end
        bus.wr_ptr_gray = 9'h000;             // bin 0: one entry left
        repeat (3) @(negedge sys_clk);
        vectors++;
        if (st !== {1'b0, 1'b1, 8'd255, 9'h100, 9'd1}) begin
            miscompares++;
            $display("FAIL wrap_one_entry got %h want %h", st, {1'b0, 1'b1, 8'd255, 9'h100, 9'd1});
        end
        bus.rd_req = 1'b1;
        #1;
        vectors++;
        if (bus.rd_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_ack got %b want 1", bus.rd_ack);
        end
        @(negedge sys_clk);
        bus.rd_req = 1'b0;
        vectors++;
        if (st !== {1'b1, 1'b1, 8'd0, 9'h000, 9'd0}) begin
            miscompares++;
            $display("FAIL wrap_after got %h want %h", st, {1'b1, 1'b1, 8'd0, 9'h000, 9'd0});
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus.wr_ptr_gray = 9'h00C;             // bin 8
        repeat (3) @(negedge sys_clk);
        pop_n(3);
        vectors++;
        if (st !== {1'b0, 1'b0, 8'd3, 9'h002, 9'd5}) begin
            miscompares++;
            $display("FAIL midop_pre got %h want %h", st, {1'b0, 1'b0, 8'd3, 9'h002, 9'd5});
        end
        sys_rst = 1'b1;
        bus.rd_req = 1'b1;
        bus.wr_ptr_gray = 9'h000;
        #1;
        vectors++;
        if (bus.rd_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_ack_in_reset got %b want 0", bus.rd_ack);
        end
        @(negedge sys_clk);
        vectors++;
        if (st !== {1'b1, 1'b1, 8'd0, 9'h000, 9'd0}) begin
            miscompares++;
            $display("FAIL midop_reset got %h want %h", st, {1'b1, 1'b1, 8'd0, 9'h000, 9'd0});
        end
        sys_rst = 1'b0;
        bus.rd_req = 1'b0;
        repeat (3) @(negedge sys_clk);
        vectors++;
        if (st !== {1'b1, 1'b1, 8'd0, 9'h000, 9'd0}) begin
            miscompares++;
            $display("FAIL midop_settled got %h want %h", st, {1'b1, 1'b1, 8'd0, 9'h000, 9'd0});
        end
    endtask

    initial begin
        bus.wr_ptr_gray = 9'h000;
        bus.rd_req = 1'b0;
        test_reset();
        test_write_pop();
        test_pop_empty();
        test_full();
        test_almost_empty();
        test_simul_pop_advance();
        test_wrap();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
